soc_system_onchip_memory_burst: RTL and testbench
=================================================

# soc_system_onchip_memory_burst

Parametrised on-chip RAM exposed as a pipelined, burst-capable Avalon-MM slave for the HPS-to-FPGA lightweight and full bridges in soc_system. It is the successor to the fixed 32-bit, single-beat on-chip memory. It adds configurable data width and depth, `readdatavalid`-based pipelined reads with an optional output register, incrementing read/write bursts, `waitrequest` back-pressure, and defined out-of-range behaviour. Memory is inferred RAM, optionally preloaded from a hex file.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8.
- ADDR_WIDTH, 16, word-address width.
- DEPTH, 40000, number of words; at most 2^ADDR_WIDTH.
- BURST_WIDTH, 4, width of `burstcount`; maximum burst is 2^BURST_WIDTH−1 beats.
- OUTPUT_REG, 1, adds one output register stage to read data (0 or 1).
- INIT_FILE, "", hex preload file; empty means contents are undefined at configuration.

Ports:
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high reset.
- clken, in, 1, clock enable; low freezes all state and the read pipeline.
- chipselect, in, 1, slave select.
- read, in, 1, read command.
- write, in, 1, write command or write beat.
- address, in, ADDR_WIDTH, word address of the first beat.
- burstcount, in, BURST_WIDTH, beats in the burst; 0 is treated as 1.
- byteenable, in, DATA_WIDTH/8, per-byte write enable.
- writedata, in, DATA_WIDTH, write data.
- waitrequest, out, 1, slave not accepting.
- readdata, out, DATA_WIDTH, read data.
- readdatavalid, out, 1, `readdata` qualifier, one per beat.

## Operation
- States: IDLE, WR_BURST, RD_BURST. Reset enters IDLE.
- Accept condition: chipselect & (read | write) & ~waitrequest & clken.
- If read and write are asserted together in IDLE, the write wins and the read is dropped.
- **IDLE, write accepted (burst N):**
  - Write beat 0 at `address`, byte-masked by `byteenable`.
  - If N>1: latch next address = address+1 and remaining = N−1, then go to WR_BURST.
- **WR_BURST:**
  - Each accepted cycle with write=1 writes the next address, increments the address and decrements remaining.
  - Cycles with write=0 are idle beats.
  - `address`, `burstcount` and `read` are ignored.
  - Returns to IDLE after the beat that brings remaining to 0.
- **IDLE, read accepted (burst N):**
  - Beat 0 issues to the RAM in the same cycle.
  - If N>1: go to RD_BURST and issue one beat per enabled cycle at consecutive addresses until N beats are issued, then return to IDLE.
- **RD_BURST:** all inputs are ignored.
- **waitrequest:**
  - 1 while reset is asserted, in RD_BURST, or when clken=0.
  - Otherwise 0.
  - Combinational from state and clken only; it never depends on `read` or `write`.
- **Address arithmetic:**
  - Burst addresses increment modulo 2^ADDR_WIDTH.
  - Any beat address ≥ DEPTH: writes are discarded; reads still produce a beat with readdatavalid=1 and readdata=0.
- **Read pipeline:**
  - Issued beats carry a valid bit through 1+OUTPUT_REG stages.
  - Beats are returned in issue order and never reordered or dropped.
  - A new command can be accepted in IDLE while earlier beats are still draining.
- **Reset mid-operation:**
  - State returns to IDLE, the burst is abandoned and in-flight beats are flushed (readdatavalid=0).
  - RAM contents are retained.
- **Reset values:** waitrequest=1, readdatavalid=0, readdata=0, internal counters 0.

## Timing
- Write: data is in RAM at the clock edge ending the accept cycle. A read issued in the next cycle returns the new data.
- Read latency: a beat issued in cycle k gives readdatavalid=1 in cycle k+1+OUTPUT_REG.
- Read burst of N with OUTPUT_REG=1, accepted in cycle 0:
  - waitrequest=1 in cycles 1..N−1, 0 in cycle N.
  - readdatavalid=1 in cycles 2..N+1.
- Sustained throughput is one beat per enabled cycle for both read and write.
- clken=0 in cycle k: no state, address, counter or pipeline change. readdata and readdatavalid hold their values; a held valid is not counted as a new beat.
- Reset assertion takes effect asynchronously. Deassertion is synchronised by the system; the first accept can occur in the first enabled cycle after release.

## Test plan
- Single write then read: write 0xDEADBEEF to 0x0010 (byteenable=0xF), then read 0x0010 → readdatavalid 2 cycles after accept (OUTPUT_REG=1), readdata=0xDEADBEEF.
- Byte enables: write 0x11223344 to 0x0020 with byteenable=0x5 over existing 0xFFFFFFFF → read returns 0xFF22FF44.
- Read burst of 8 from 0x0100 after writing 0x100+i at each address → waitrequest high 7 cycles, then 8 contiguous valid beats 0x100..0x107 in order.
- Write burst of 4 at 0x9C3E with DEPTH=40000 (beats at 0x9C3E, 0x9C3F, 0x9C40, 0x9C41) with write deasserted for 2 cycles mid-burst → first two stored; the out-of-range beats are discarded and read back as 0 with readdatavalid high; the burst completes after 4 write beats.
- clken low for 3 cycles in the middle of a 4-beat read → beats are delayed by exactly 3 cycles, no beat is lost or duplicated, waitrequest=1 throughout the stall.
- Reset asserted in cycle 2 of an 8-beat read → readdatavalid=0 immediately, state IDLE, waitrequest=0 after release; a subsequent read returns the previously written data intact.

Source files
------------

// File: rtl/soc_system_onchip_memory_burst_if.sv
// Avalon-MM slave bus bundle for the burst on-chip memory.
// The master modport is the bridge side; the slave modport is the RAM side.
interface soc_system_onchip_memory_burst_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int BURST_WIDTH = 4
);
   logic                      chipselect;
   logic                      read;
   logic                      write;
   logic [ADDR_WIDTH-1:0]     address;
   logic [BURST_WIDTH-1:0]    burstcount;
   logic [DATA_WIDTH/8-1:0]   byteenable;
   logic [DATA_WIDTH-1:0]     writedata;
   logic                      waitrequest;
   logic [DATA_WIDTH-1:0]     readdata;
   logic                      readdatavalid;

   modport master (
      output chipselect, read, write, address, burstcount, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  chipselect, read, write, address, burstcount, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/soc_system_onchip_memory_burst.sv
// Burst-capable pipelined Avalon-MM on-chip RAM: incrementing bursts, readdatavalid
// read returns through 1+OUTPUT_REG stages, out-of-range beats read as zero.
module soc_system_onchip_memory_burst #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 40000,
   parameter int BURST_WIDTH = 4,
   parameter int OUTPUT_REG  = 1,
   parameter     INIT_FILE   = ""
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  clken,
   soc_system_onchip_memory_burst_if.slave       bus
);
   localparam int STAGES = 1 + OUTPUT_REG;
   localparam int NBE    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0]  ONE_A = 1;
   localparam logic [BURST_WIDTH-1:0] ONE_B = 1;

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_e;

   state_e                          state_q;
   logic [ADDR_WIDTH-1:0]           addr_q;
   logic [BURST_WIDTH-1:0]          remain_q;
   logic [STAGES:1]                 vld_pipe;
   logic [STAGES:1][DATA_WIDTH-1:0] dat_q;
   logic [DATA_WIDTH-1:0]           mem [DEPTH];

   logic                   wait_req, accept, wr_en, rd_issue;
   logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;
   logic [BURST_WIDTH-1:0] bcount;

   // Back-pressure depends only on reset, state and clken so masters never see a loop.
   assign wait_req        = reset | (state_q == RD_BURST) | ~clken;
   assign accept          = bus.chipselect & (bus.read | bus.write) & ~wait_req;
   assign bcount          = (bus.burstcount == '0) ? ONE_B : bus.burstcount;
   assign bus.waitrequest = wait_req;

   always_comb begin
      wr_en    = 1'b0;
      rd_issue = 1'b0;
      wr_addr  = bus.address;
      rd_addr  = bus.address;
      case (state_q)
         IDLE: begin
            wr_en    = accept & bus.write;
            rd_issue = accept & bus.read & ~bus.write;
         end
         WR_BURST: begin
            wr_en   = accept & bus.write;
            wr_addr = addr_q;
         end
         RD_BURST: begin
            rd_issue = clken;
            rd_addr  = addr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if ((wr_en || rd_issue) && bcount > ONE_B) begin
                  state_q  <= wr_en ? WR_BURST : RD_BURST;
                  addr_q   <= bus.address + ONE_A;
                  remain_q <= bcount - ONE_B;
               end
            end
            WR_BURST, RD_BURST: begin
               if (wr_en || rd_issue) begin
                  addr_q   <= addr_q + ONE_A;
                  remain_q <= remain_q - ONE_B;
                  if (remain_q == ONE_B) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && 32'(wr_addr) < DEPTH) begin
         for (int b = 0; b < NBE; b++)
            if (bus.byteenable[b]) mem[wr_addr][b*8 +: 8] <= bus.writedata[b*8 +: 8];
      end
   end

   // Whole read pipeline freezes with clken so held beats are never re-issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         dat_q    <= '0;
      end else if (clken) begin
         vld_pipe[1] <= rd_issue;
         dat_q[1]    <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
         for (int i = 2; i <= STAGES; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_q[i]    <= dat_q[i-1];
         end
      end
   end

   assign bus.readdata      = dat_q[STAGES];
   assign bus.readdatavalid = vld_pipe[STAGES];
endmodule

// File: tb/tb_soc_system_onchip_memory_burst.sv
// Directed bench for the burst on-chip RAM (DEPTH=40000, OUTPUT_REG=1).
module tb_soc_system_onchip_memory_burst;
   logic clk = 1'b0;
   logic reset;
   logic clken;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   soc_system_onchip_memory_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BURST_WIDTH(4)) bus ();

   soc_system_onchip_memory_burst #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(40000),
      .BURST_WIDTH(4), .OUTPUT_REG(1), .INIT_FILE("")
   ) dut (
      .clk(clk), .reset(reset), .clken(clken), .bus(bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.burstcount = 4'd1;
      bus.byteenable = 4'hF;
   endtask

   task automatic wr1(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.read       = 1'b0;
      bus.address    = a;
      bus.burstcount = 4'd1;
      bus.byteenable = be;
      bus.writedata  = d;
      tick;
      idle_bus;
   endtask

   task automatic rd1(input string tag, input logic [15:0] a, input logic [31:0] exp);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.write      = 1'b0;
      bus.address    = a;
      bus.burstcount = 4'd1;
      tick;
      idle_bus;
      chk({tag, "_rdv_c1"}, 32'(bus.readdatavalid), 32'd0);
      tick;
      chk({tag, "_rdv_c2"}, 32'(bus.readdatavalid), 32'd1);
      chk({tag, "_data"}, bus.readdata, exp);
   endtask

   initial begin
      int beats;
      reset = 1'b1;
      clken = 1'b1;
      idle_bus;
      bus.address   = '0;
      bus.writedata = '0;
      #12;
      chk("rst_waitreq", 32'(bus.waitrequest), 32'd1);
      chk("rst_rdv", 32'(bus.readdatavalid), 32'd0);
      chk("rst_rdata", bus.readdata, 32'd0);
      tick;
      reset = 1'b0;
      tick;
      chk("post_rst_waitreq", 32'(bus.waitrequest), 32'd0);

      // Single write then read
      wr1(16'h0010, 32'hDEADBEEF, 4'hF);
      rd1("single", 16'h0010, 32'hDEADBEEF);

      // Byte enables over existing all-ones word
      wr1(16'h0020, 32'hFFFFFFFF, 4'hF);
      wr1(16'h0020, 32'h11223344, 4'h5);
      rd1("byteen", 16'h0020, 32'hFF22FF44);

      // Write burst of 8 at 0x100, then read burst of 8
      for (int i = 0; i < 8; i++) begin
         bus.chipselect = 1'b1;
         bus.write      = 1'b1;
         bus.address    = 16'h0100;
         bus.burstcount = 4'd8;
         bus.byteenable = 4'hF;
         bus.writedata  = 32'h100 + 32'(i);
         #1;
         if (i == 3) chk("wrburst_waitreq", 32'(bus.waitrequest), 32'd0);
         tick;
      end
      idle_bus;
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 16'h0100;
      bus.burstcount = 4'd8;
      tick;
      idle_bus;
      beats = 0;
      for (int c = 1; c <= 11; c++) begin
         chk($sformatf("rdburst_waitreq_c%0d", c), 32'(bus.waitrequest), 32'(c <= 7));
         chk($sformatf("rdburst_rdv_c%0d", c), 32'(bus.readdatavalid), 32'(c >= 2 && c <= 9));
         if (bus.readdatavalid) begin
            chk($sformatf("rdburst_data_b%0d", beats), bus.readdata, 32'h100 + 32'(beats));
            beats++;
         end
         tick;
      end
      chk("rdburst_beats", 32'(beats), 32'd8);

      // Write burst straddling DEPTH with two idle beats mid-burst
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = 16'h9C3E;
      bus.burstcount = 4'd4;
      bus.byteenable = 4'hF;
      bus.writedata  = 32'hA0A0_0000;
      tick;
      bus.address    = 16'h0000;
      bus.writedata  = 32'hA0A0_0001;
      tick;
      bus.write = 1'b0;
      tick;
      #1 chk("wrburst_idle_waitreq", 32'(bus.waitrequest), 32'd0);
      tick;
      bus.write     = 1'b1;
      bus.writedata = 32'hA0A0_0002;
      tick;
      bus.writedata = 32'hA0A0_0003;
      tick;
      idle_bus;
      wr1(16'h0030, 32'h0000_0055, 4'hF);
      rd1("after_burst", 16'h0030, 32'h0000_0055);
      rd1("oor_9c3e", 16'h9C3E, 32'hA0A0_0000);
      rd1("oor_9c3f", 16'h9C3F, 32'hA0A0_0001);
      rd1("oor_9c40", 16'h9C40, 32'h0);
      rd1("oor_9c41", 16'h9C41, 32'h0);

      // clken low for 3 cycles inside a 4-beat read
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 16'h0100;
      bus.burstcount = 4'd4;
      tick;
      idle_bus;
      beats = 0;
      for (int c = 1; c <= 10; c++) begin
         clken = !(c >= 2 && c <= 4);
         #1;
         chk($sformatf("stall_waitreq_c%0d", c), 32'(bus.waitrequest), 32'(c <= 6));
         chk($sformatf("stall_rdv_c%0d", c), 32'(bus.readdatavalid), 32'(c >= 2 && c <= 8));
         if (clken && bus.readdatavalid) begin
            chk($sformatf("stall_beat%0d_c%0d", beats, c), bus.readdata, 32'h100 + 32'(beats));
            chk($sformatf("stall_beat%0d_cycle", beats), 32'(c), 32'(5 + beats));
            beats++;
         end
         tick;
      end
      clken = 1'b1;
      chk("stall_beats", 32'(beats), 32'd4);

      // Reset asserted in cycle 2 of an 8-beat read
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 16'h0100;
      bus.burstcount = 4'd8;
      tick;
      idle_bus;
      tick;
      chk("midrst_rdv_before", 32'(bus.readdatavalid), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_rdv", 32'(bus.readdatavalid), 32'd0);
      chk("midrst_waitreq", 32'(bus.waitrequest), 32'd1);
      chk("midrst_rdata", bus.readdata, 32'd0);
      tick;
      reset = 1'b0;
      tick;
      chk("midrst_release_waitreq", 32'(bus.waitrequest), 32'd0);
      chk("midrst_release_rdv", 32'(bus.readdatavalid), 32'd0);
      rd1("midrst_retained", 16'h0010, 32'hDEADBEEF);
      rd1("midrst_retained2", 16'h0105, 32'h105);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
